station_display_seq: RTL and testbench
======================================

# station_display_seq

Registered, parametrised successor to the combinational station/letter output stage. It latches a one-hot current-station selection and queues target requests given as an index relative to that station. It drives two 4-bit hex display digits: current station on `v1`, head-of-queue target on `v2`, with a pop handshake to advance. It sits between the button/request decoding logic and the 7-segment display driver.

## Interface
- `N_ST`, 4, number of stations (2..12); letters start at `DIG_BASE`
- `DEPTH`, 4, target queue depth (power of two, ≥2)
- `DIG_BASE`, 4'hA, display code of station 0; elaboration error if `DIG_BASE+N_ST-1 > 15`
- `BLINK_DIV`, 8, clock cycles per blink half-period (used only when blink is compiled in)
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `src_sel`  in  N_ST  one-hot current station
- `src_load`  in  1  strobe: latch `src_sel`
- `tgt_idx`  in  $clog2(N_ST-1) (min 1)  target index among the other N_ST-1 stations, ascending, skipping current
- `tgt_push`  in  1  strobe: enqueue target
- `tgt_pop`  in  1  ack: head target served, advance queue
- `v1`  out  4  current-station digit
- `v2`  out  4  head-target digit
- `tgt_valid`  out  1  queue non-empty
- `full`  out  1  queue holds DEPTH entries
- `err`  out  1  one-cycle pulse on any rejected command
- `ovf`  out  1  sticky: a push was dropped because the queue was full

## Operation
- States: IDLE (no station latched), READY (station latched, queue empty), SERVE (queue non-empty).
- IDLE→READY on a valid `src_load`. READY→SERVE on an accepted push. SERVE→READY when a pop empties the queue. A `src_load` in any state flushes the queue → READY, then applies a same-cycle push.
- `src_load` with `src_sel` not one-hot: ignored, `err` pulses.
- Relative→absolute mapping at push time: abs = idx if idx < cur, else idx+1. The queue stores absolute indices, so later source changes do not reinterpret entries.
- Push in IDLE or with idx ≥ N_ST-1: dropped, `err` pulses.
- Push when full without same-cycle pop: dropped, `ovf` set (cleared only by `rst`), `err` pulses.
- Push and pop in the same cycle when full: both accepted; count unchanged.
- Pop when empty: ignored, no error.
- `v1` = DIG_BASE+cur in READY/SERVE, 4'h0 in IDLE. `v2` = DIG_BASE+head in SERVE, 4'h0 otherwise.
- Queue pointers wrap modulo DEPTH. Count width is $clog2(DEPTH)+1.

## Timing
- Reset values: `v1`=0, `v2`=0, `tgt_valid`=0, `full`=0, `err`=0, `ovf`=0; state IDLE, queue empty.
- `rst` mid-operation discards the queue and the latched station in the same edge.
- All outputs are registered. `v1` updates 1 cycle after `src_load`. `v2`/`tgt_valid` update 1 cycle after a push into an empty queue, and 1 cycle after a pop.
- `err` is asserted for exactly the cycle after the offending command.
- `full` reflects the post-edge count; a push and pop in the same cycle never both fail.

## Configuration
- `STATION_DISP_BLINK_EN` defined: in SERVE, `v2` alternates between the target digit and 4'hF (blank code) every `BLINK_DIV` cycles. The blink counter restarts at each head change so a new target is shown immediately. `v1` is unaffected.
- Macro undefined: no blink counter is synthesised; `v2` is steady.

## Structure
- Shared package `station_pkg`: `DIG_BLANK`=4'hF, `DIG_NONE`=4'h0, the state enum (IDLE/READY/SERVE), and a `rel_to_abs` function.
- One natural sub-module: `station_fifo`, a parametrised synchronous FIFO with push/pop/full/empty/count, instanced once.

## Test plan
- Reset, then `src_load` with `src_sel`=4'b0001 → next cycle `v1`=4'hA, `v2`=0, `tgt_valid`=0.
- Station A, push idx 0,1,2 → `v2`=4'hB. Pop: `v2`=4'hC. Pop: `v2`=4'hD. Pop: `v2`=0, `tgt_valid`=0.
- Station C (4'b0100), push idx 1 → `v2`=4'hB. Load D, push idx 2 same cycle → queue flushed, `v1`=4'hD, `v2`=4'hC, count 1.
- Fill 4 entries, push again → `err` pulse, `ovf`=1, `full`=1. Push+pop together while full → count stays 4, head advances.
- `src_sel`=4'b0110 load, or push idx 3 with N_ST=4 → `err` pulse, state unchanged. Push in IDLE → `err` pulse.
- With `STATION_DISP_BLINK_EN`, BLINK_DIV=8 → `v2` toggles target/4'hF every 8 cycles. Assert `rst` mid-queue → all outputs 0 next cycle.

Source files
------------

// File: rtl/station_pkg.sv
// Shared types and helpers for the station display sequencer.
package station_pkg;

  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [3:0] DIG_NONE  = 4'h0;

  typedef enum logic [1:0] {IDLE, READY, SERVE} state_t;

  // Index among the other stations (ascending, current skipped) -> absolute index
  function automatic logic [3:0] rel_to_abs(input logic [3:0] idx, input logic [3:0] cur);
    return (idx < cur) ? idx : idx + 4'd1;
  endfunction

endpackage

// File: rtl/station_fifo.sv
// Synchronous FIFO with flush. Push/pop are trusted (already qualified by
// the caller). Exposes the post-edge count and head so the owner can
// register display values without an extra cycle of latency.
module station_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt,
  output logic [W-1:0]  head_nxt
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_base, rd_base;
  logic [CW-1:0] cnt_base;

  // Flush empties the queue first; a same-cycle push then lands in slot 0
  always_comb begin
    wr_base   = flush ? '0 : wr_ptr;
    rd_base   = flush ? '0 : rd_ptr;
    cnt_base  = flush ? '0 : count;
    count_nxt = cnt_base + CW'(push) - CW'(pop);
    if (pop)
      head_nxt = (cnt_base >= CW'(2)) ? mem[rd_base + AW'(1)] : din;
    else
      head_nxt = (cnt_base != '0) ? mem[rd_base] : din;
  end

  // Storage; when full with push+pop the write slot equals the popped slot
  always_ff @(posedge clk) begin
    if (push) mem[wr_base] <= din;
  end

  // Pointers wrap naturally (DEPTH is a power of two)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_base + AW'(push);
      rd_ptr <= rd_base + AW'(pop);
      count  <= count_nxt;
    end
  end

endmodule

// File: rtl/station_display_seq.sv
// Station display sequencer: latches the current station, queues targets
// (stored as absolute indices) and drives two registered hex digits.
// Optional build macro: STATION_DISP_BLINK_EN blinks v2 while serving.
module station_display_seq
  import station_pkg::*;
#(
  parameter int         N_ST      = 4,
  parameter int         DEPTH     = 4,
  parameter logic [3:0] DIG_BASE  = 4'hA,
  parameter int         BLINK_DIV = 8,
  localparam int        IW        = $clog2(N_ST),
  localparam int        TW        = (N_ST > 2) ? $clog2(N_ST - 1) : 1,
  localparam int        CW        = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_ST-1:0] src_sel,
  input  logic            src_load,
  input  logic [TW-1:0]   tgt_idx,
  input  logic            tgt_push,
  input  logic            tgt_pop,
  output logic [3:0]      v1,
  output logic [3:0]      v2,
  output logic            tgt_valid,
  output logic            full,
  output logic            err,
  output logic            ovf
);

  if (int'(DIG_BASE) + N_ST - 1 > 15) begin : g_bad_base
    $error("DIG_BASE + N_ST - 1 exceeds a 4-bit digit");
  end
  if (N_ST < 2 || N_ST > 12 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || BLINK_DIV < 1) begin : g_bad_param
    $error("station_display_seq parameter out of range");
  end

  state_t        state, state_nxt;
  logic [IW-1:0] cur, sel_idx, cur_nxt;
  logic [IW-1:0] abs_idx;
  logic [IW-1:0] head_nxt;
  logic [CW-1:0] count, count_nxt, count_eff;
  logic          load_ok, load_bad, active, idx_ok;
  logic          push_acc, pop_acc, push_full_drop, err_nxt;
  logic [3:0]    v2_nxt;

  // One-hot decode of the requested station
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N_ST; i++)
      if (src_sel[i]) sel_idx = IW'(i);
  end

  // Command qualification; a good load flushes before a same-cycle push
  always_comb begin
    load_ok        = src_load && $onehot(src_sel);
    load_bad       = src_load && !$onehot(src_sel);
    active         = load_ok || (state != IDLE);
    idx_ok         = int'(tgt_idx) < N_ST - 1;
    cur_nxt        = load_ok ? sel_idx : cur;
    abs_idx        = IW'(rel_to_abs(4'(tgt_idx), 4'(cur_nxt)));
    count_eff      = load_ok ? '0 : count;
    pop_acc        = tgt_pop && (count_eff != '0);
    push_acc       = tgt_push && active && idx_ok && ((count_eff != CW'(DEPTH)) || pop_acc);
    push_full_drop = tgt_push && active && idx_ok && (count_eff == CW'(DEPTH)) && !pop_acc;
    err_nxt        = load_bad || (tgt_push && (!active || !idx_ok)) || push_full_drop;
    if (!active)                state_nxt = IDLE;
    else if (count_nxt != '0)   state_nxt = SERVE;
    else                        state_nxt = READY;
  end

  station_fifo #(.DEPTH(DEPTH), .W(IW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (load_ok),
    .push      (push_acc),
    .pop       (pop_acc),
    .din       (abs_idx),
    .count     (count),
    .count_nxt (count_nxt),
    .head_nxt  (head_nxt)
  );

`ifdef STATION_DISP_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV + 1);
  logic [BW-1:0] blink_cnt, blink_cnt_nxt;
  logic          blink_ph, blink_ph_nxt, head_chg;

  // Blink phase restarts whenever a different target reaches the head
  always_comb begin
    head_chg      = load_ok || pop_acc || (push_acc && count_eff == '0);
    blink_cnt_nxt = blink_cnt + BW'(1);
    blink_ph_nxt  = blink_ph;
    if (state_nxt != SERVE || head_chg) begin
      blink_cnt_nxt = '0;
      blink_ph_nxt  = 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt_nxt = '0;
      blink_ph_nxt  = !blink_ph;
    end
    v2_nxt = (state_nxt != SERVE) ? DIG_NONE :
             blink_ph_nxt         ? DIG_BLANK : DIG_BASE + 4'(head_nxt);
  end

  // Blink counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_nxt;
      blink_ph  <= blink_ph_nxt;
    end
  end
`else
  // Steady head digit while serving
  always_comb v2_nxt = (state_nxt == SERVE) ? DIG_BASE + 4'(head_nxt) : DIG_NONE;
`endif

  // Control FSM with registered display/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      v1        <= DIG_NONE;
      v2        <= DIG_NONE;
      tgt_valid <= 1'b0;
      full      <= 1'b0;
      err       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur       <= cur_nxt;
      v1        <= (state_nxt == IDLE) ? DIG_NONE : DIG_BASE + 4'(cur_nxt);
      v2        <= v2_nxt;
      tgt_valid <= count_nxt != '0;
      full      <= count_nxt == CW'(DEPTH);
      err       <= err_nxt;
      ovf       <= ovf || push_full_drop;
    end
  end

endmodule

// File: tb/tb_station_display_seq.sv
// Directed bench: each step pushes its expected outputs into a scoreboard
// queue; a monitor on the falling edge pops and compares.
module tb_station_display_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] src_sel;
  logic       src_load;
  logic [1:0] tgt_idx;
  logic       tgt_push, tgt_pop;
  logic [3:0] v1, v2;
  logic       tgt_valid, full, err, ovf;

  typedef struct {
    string      name;
    logic [3:0] v1, v2;
    logic       tv, full, err, ovf;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  station_display_seq dut (
    .clk(clk), .rst(rst), .src_sel(src_sel), .src_load(src_load),
    .tgt_idx(tgt_idx), .tgt_push(tgt_push), .tgt_pop(tgt_pop),
    .v1(v1), .v2(v2), .tgt_valid(tgt_valid), .full(full), .err(err), .ovf(ovf)
  );

  // Monitor: outputs are registered, so each step's result is visible at the next negedge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (v1 !== e.v1 || v2 !== e.v2 || tgt_valid !== e.tv ||
            full !== e.full || err !== e.err || ovf !== e.ovf) begin
          bad++;
          $display("FAIL %s: got v1=%h v2=%h tv=%b full=%b err=%b ovf=%b, want v1=%h v2=%h tv=%b full=%b err=%b ovf=%b",
                   e.name, v1, v2, tgt_valid, full, err, ovf, e.v1, e.v2, e.tv, e.full, e.err, e.ovf);
        end
      end
    end
  end

  task automatic step(input string name, input logic r, input logic ld, input logic [3:0] sel,
                      input logic ps, input logic [1:0] idx, input logic pp,
                      input logic [3:0] ev1, input logic [3:0] ev2,
                      input logic etv, input logic efull, input logic eerr, input logic eovf);
    exp_t e;
    #1;
    rst = r; src_load = ld; src_sel = sel; tgt_push = ps; tgt_idx = idx; tgt_pop = pp;
    @(posedge clk);
    e.name = name; e.v1 = ev1; e.v2 = ev2; e.tv = etv; e.full = efull; e.err = eerr; e.ovf = eovf;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; src_sel = '0; src_load = 1'b0; tgt_idx = '0; tgt_push = 1'b0; tgt_pop = 1'b0;
    @(posedge clk);
    //    name            rst ld sel     ps idx pp   v1    v2    tv fu er ov
    step("reset",         1, 0, 4'b0000, 0, 0, 0,  4'h0, 4'h0, 0, 0, 0, 0);
    step("push_idle",     0, 0, 4'b0000, 1, 0, 0,  4'h0, 4'h0, 0, 0, 1, 0);
    step("load_a",        0, 1, 4'b0001, 0, 0, 0,  4'hA, 4'h0, 0, 0, 0, 0);
    step("push_rel0",     0, 0, 4'b0000, 1, 0, 0,  4'hA, 4'hB, 1, 0, 0, 0);
    step("push_rel1",     0, 0, 4'b0000, 1, 1, 0,  4'hA, 4'hB, 1, 0, 0, 0);
    step("push_rel2",     0, 0, 4'b0000, 1, 2, 0,  4'hA, 4'hB, 1, 0, 0, 0);
    step("pop_to_c",      0, 0, 4'b0000, 0, 0, 1,  4'hA, 4'hC, 1, 0, 0, 0);
    step("pop_to_d",      0, 0, 4'b0000, 0, 0, 1,  4'hA, 4'hD, 1, 0, 0, 0);
    step("pop_last",      0, 0, 4'b0000, 0, 0, 1,  4'hA, 4'h0, 0, 0, 0, 0);
    step("pop_empty",     0, 0, 4'b0000, 0, 0, 1,  4'hA, 4'h0, 0, 0, 0, 0);
    step("load_c",        0, 1, 4'b0100, 0, 0, 0,  4'hC, 4'h0, 0, 0, 0, 0);
    step("push_below",    0, 0, 4'b0000, 1, 1, 0,  4'hC, 4'hB, 1, 0, 0, 0);
    step("load_d_push",   0, 1, 4'b1000, 1, 2, 0,  4'hD, 4'hC, 1, 0, 0, 0);
    step("fill2",         0, 0, 4'b0000, 1, 0, 0,  4'hD, 4'hC, 1, 0, 0, 0);
    step("fill3",         0, 0, 4'b0000, 1, 1, 0,  4'hD, 4'hC, 1, 0, 0, 0);
    step("fill4",         0, 0, 4'b0000, 1, 2, 0,  4'hD, 4'hC, 1, 1, 0, 0);
    step("push_full",     0, 0, 4'b0000, 1, 0, 0,  4'hD, 4'hC, 1, 1, 1, 1);
    step("push_pop_full", 0, 0, 4'b0000, 1, 1, 1,  4'hD, 4'hA, 1, 1, 0, 1);
    step("bad_sel",       0, 1, 4'b0110, 0, 0, 0,  4'hD, 4'hA, 1, 1, 1, 1);
    step("bad_idx",       0, 0, 4'b0000, 1, 3, 0,  4'hD, 4'hA, 1, 1, 1, 1);
    step("pop_after",     0, 0, 4'b0000, 0, 0, 1,  4'hD, 4'hB, 1, 0, 0, 1);
    step("rst_mid",       1, 0, 4'b0000, 1, 0, 0,  4'h0, 4'h0, 0, 0, 0, 0);
    step("post_rst",      0, 0, 4'b0000, 0, 0, 1,  4'h0, 4'h0, 0, 0, 0, 0);
    step("reload_b_pp",   0, 1, 4'b0010, 1, 1, 1,  4'hB, 4'hC, 1, 0, 0, 0);
    step("idle_hold",     0, 0, 4'b0000, 0, 0, 0,  4'hB, 4'hC, 1, 0, 0, 0);
    #1;
    src_load = 1'b0; tgt_push = 1'b0; tgt_pop = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
